// File: rtl/flash_pkg.sv
// Shared definitions for the 32-bit bus to 16-bit NOR flash bridge.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RY_WAIT,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_e;

  localparam int T_ACC_DEF      = 5;
  localparam int T_WP_DEF       = 3;
  localparam int RY_TIMEOUT_DEF = 1048576;

  localparam logic [1:0] HALF0_OFF = 2'b00;
  localparam logic [1:0] HALF1_OFF = 2'b10;

  // Half 0 carries bits [31:16] (big-endian), half 1 carries bits [15:0].
  function automatic logic [26:0] half_addr(input logic [24:0] word, input logic half);
    return {word, (half ? HALF1_OFF : HALF0_OFF)};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous flash ready/busy line.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/flash_ctrl.sv
// 32-bit bus slave that splits each access into two big-endian 16-bit flash cycles,
// with registered flash strobes, ready/busy polling and a ready-timeout fault.
module flash_ctrl
  import flash_pkg::*;
#(
  parameter int T_ACC      = T_ACC_DEF,
  parameter int T_WP       = T_WP_DEF,
  parameter int RY_TIMEOUT = RY_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        fault,
  output logic [26:0] fl_addr,
  output logic [15:0] fl_dout,
  output logic        fl_dout_en,
  input  logic [15:0] fl_din,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  output logic        fl_we_n,
  input  logic        fl_ry
);

  state_e      state_q, state_d;
  logic        half_q, half_d;
  logic        pend_q, pend_d;
  logic        is_rd_q, is_rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] rd_hi_q, rd_hi_d;
  logic [31:0] readdata_q, readdata_d;
  logic        fault_q, fault_d;
  logic [26:0] fl_addr_q, fl_addr_d;
  logic [15:0] fl_dout_q, fl_dout_d;
  logic        fl_dout_en_q, fl_dout_en_d;
  logic        fl_ce_n_q, fl_ce_n_d;
  logic        fl_oe_n_q, fl_oe_n_d;
  logic        fl_we_n_q, fl_we_n_d;
  logic        ry_s;
  logic        need_h0, need_h1;
  logic        unused_addr;

  sync2 u_ry_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fl_ry),
    .q     (ry_s)
  );

  assign need_h0     = |byteenable[3:2];
  assign need_h1     = |byteenable[1:0];
  assign unused_addr = ^address[1:0];

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    pend_d     = pend_q;
    is_rd_d    = is_rd_q;
    cnt_d      = cnt_q + 32'd1;
    rd_hi_d    = rd_hi_q;
    readdata_d = readdata_q;
    fault_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (read) begin
          is_rd_d = 1'b1;
          half_d  = 1'b0;
          pend_d  = 1'b1;
          state_d = ry_s ? RD : RY_WAIT;
        end else if (write) begin
          is_rd_d = 1'b0;
          half_d  = !need_h0;
          pend_d  = 1'b1;
          if (!need_h0 && !need_h1) begin
            pend_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = ry_s ? WR_SETUP : RY_WAIT;
          end
        end
      end
      RY_WAIT: begin
        // The first cycle never exits, so a stale ready from before the write is ignored.
        if (cnt_q >= 32'd1 && ry_s) begin
          cnt_d = '0;
          if (pend_q) state_d = is_rd_q ? RD : WR_SETUP;
          else        state_d = DONE;
        end else if (cnt_q == 32'(RY_TIMEOUT - 1)) begin
          cnt_d      = '0;
          fault_d    = 1'b1;
          readdata_d = '1;
          state_d    = DONE;
        end
      end
      RD: begin
        if (cnt_q == 32'(T_ACC - 1)) begin
          cnt_d = '0;
          if (!half_q) begin
            rd_hi_d = fl_din;
            half_d  = 1'b1;
          end else begin
            readdata_d = {rd_hi_q, fl_din};
            state_d    = DONE;
          end
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == 32'(T_WP - 1)) begin
          cnt_d   = '0;
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        cnt_d   = '0;
        state_d = RY_WAIT;
        if (!half_q && need_h1) begin
          half_d = 1'b1;
          pend_d = 1'b1;
        end else begin
          pend_d = 1'b0;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so the flops present them for the whole state.
    fl_ce_n_d    = 1'b1;
    fl_oe_n_d    = 1'b1;
    fl_we_n_d    = 1'b1;
    fl_dout_en_d = 1'b0;
    fl_addr_d    = fl_addr_q;
    fl_dout_d    = fl_dout_q;
    unique case (state_d)
      RD: begin
        fl_ce_n_d = 1'b0;
        fl_oe_n_d = 1'b0;
        fl_addr_d = half_addr(address[26:2], half_d);
      end
      WR_SETUP: begin
        fl_ce_n_d    = 1'b0;
        fl_dout_en_d = 1'b1;
        fl_addr_d    = half_addr(address[26:2], half_d);
        fl_dout_d    = half_d ? writedata[15:0] : writedata[31:16];
      end
      WR_PULSE: begin
        fl_ce_n_d    = 1'b0;
        fl_dout_en_d = 1'b1;
        fl_we_n_d    = 1'b0;
      end
      WR_HOLD: begin
        fl_ce_n_d    = 1'b0;
        fl_dout_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      half_q       <= 1'b0;
      pend_q       <= 1'b0;
      is_rd_q      <= 1'b0;
      cnt_q        <= '0;
      rd_hi_q      <= '0;
      readdata_q   <= '0;
      fault_q      <= 1'b0;
      fl_addr_q    <= '0;
      fl_dout_q    <= '0;
      fl_dout_en_q <= 1'b0;
      fl_ce_n_q    <= 1'b1;
      fl_oe_n_q    <= 1'b1;
      fl_we_n_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      pend_q       <= pend_d;
      is_rd_q      <= is_rd_d;
      cnt_q        <= cnt_d;
      rd_hi_q      <= rd_hi_d;
      readdata_q   <= readdata_d;
      fault_q      <= fault_d;
      fl_addr_q    <= fl_addr_d;
      fl_dout_q    <= fl_dout_d;
      fl_dout_en_q <= fl_dout_en_d;
      fl_ce_n_q    <= fl_ce_n_d;
      fl_oe_n_q    <= fl_oe_n_d;
      fl_we_n_q    <= fl_we_n_d;
    end
  end

  assign waitrequest = (read | write) & (state_q != DONE);
  assign readdata    = readdata_q;
  assign fault       = fault_q;
  assign fl_addr     = fl_addr_q;
  assign fl_dout     = fl_dout_q;
  assign fl_dout_en  = fl_dout_en_q;
  assign fl_ce_n     = fl_ce_n_q;
  assign fl_oe_n     = fl_oe_n_q;
  assign fl_we_n     = fl_we_n_q;

endmodule

// File: tb/tb_flash_ctrl.sv
// Scoreboard bench for flash_ctrl: stimulus pushes expected responses and write pulses,
// monitors pop and compare when the DUT completes a transfer or releases fl_we_n.
module tb_flash_ctrl;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        flt;
  } resp_t;

  typedef struct {
    logic [26:0] addr;
    logic [15:0] data;
    int          width;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [26:0] address = '0;
  logic        read = 1'b0;
  logic        read2 = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata, readdata_2;
  logic        waitrequest, waitrequest_2;
  logic        fault, fault_2;
  logic [26:0] fl_addr, fl_addr_2;
  logic [15:0] fl_dout, fl_dout_2;
  logic        fl_dout_en, fl_dout_en_2;
  logic [15:0] fl_din;
  logic        fl_ce_n, fl_ce_n_2;
  logic        fl_oe_n, fl_oe_n_2;
  logic        fl_we_n, fl_we_n_2;
  logic        fl_ry;
  logic        ry_hold = 1'b0;
  int          busy_len = 0;
  int          busy_cnt = 0;

  int total = 0;
  int bad = 0;
  int viol = 0;

  resp_t  exp_q[$];
  resp_t  exp2_q[$];
  pulse_t pexp_q[$];

  always #5 clk = ~clk;

  flash_ctrl dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .waitrequest(waitrequest), .fault(fault), .fl_addr(fl_addr), .fl_dout(fl_dout),
    .fl_dout_en(fl_dout_en), .fl_din(fl_din), .fl_ce_n(fl_ce_n), .fl_oe_n(fl_oe_n),
    .fl_we_n(fl_we_n), .fl_ry(fl_ry)
  );

  // Second instance with a short timeout and a permanently busy flash.
  flash_ctrl #(.RY_TIMEOUT(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read2), .write(1'b0),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata_2),
    .waitrequest(waitrequest_2), .fault(fault_2), .fl_addr(fl_addr_2), .fl_dout(fl_dout_2),
    .fl_dout_en(fl_dout_en_2), .fl_din(fl_din), .fl_ce_n(fl_ce_n_2), .fl_oe_n(fl_oe_n_2),
    .fl_we_n(fl_we_n_2), .fl_ry(1'b0)
  );

  // Flash model: two fixed words, otherwise address XOR pattern; busy for busy_len after each pulse.
  assign fl_din = (fl_addr == 27'h0000100) ? 16'hDEAD :
                  (fl_addr == 27'h0000102) ? 16'hBEEF : (fl_addr[15:0] ^ 16'hA5A5);
  assign fl_ry  = !ry_hold && (busy_cnt == 0);

  always @(posedge clk) begin
    if (!fl_we_n)          busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushResp(input logic [31:0] rd, input logic chk, input logic flt, input bit to2);
    resp_t r;
    r.rd = rd; r.chk_rd = chk; r.flt = flt;
    if (to2) exp2_q.push_back(r);
    else     exp_q.push_back(r);
  endtask

  task automatic pushPulse(input logic [26:0] a, input logic [15:0] d, input int w);
    pulse_t p;
    p.addr = a; p.data = d; p.width = w;
    pexp_q.push_back(p);
  endtask

  // Issues one request, counts waitrequest-high cycles at negedges, drops the request after DONE.
  task automatic applyStimulus(input bit use2, input logic rd, input logic wr,
                               input logic [26:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, input int exp_cycles);
    int cyc;
    @(posedge clk); #1;
    address = addr; writedata = wd; byteenable = be;
    if (use2) read2 = rd;
    else begin read = rd; write = wr; end
    cyc = 0;
    @(negedge clk);
    while ((use2 ? waitrequest_2 : waitrequest) && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) begin
      total++; bad++;
      $display("[TB] FAIL completion_timeout: got no completion after %0d cycles, expected one", cyc);
    end else if (exp_cycles >= 0) begin
      checkOutput("waitreq_cycles", 32'(cyc), 32'(exp_cycles));
    end
    #1;
    read = 1'b0; write = 1'b0; read2 = 1'b0;
  endtask

  // Completion monitor for the main instance.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && (read | write) && !waitrequest) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL resp_unexpected: got readdata=%h fault=%b, expected no response", readdata, fault);
      end else begin
        r = exp_q.pop_front();
        if (r.chk_rd) checkOutput("resp_readdata", readdata, r.rd);
        checkOutput("resp_fault", 32'(fault), 32'(r.flt));
      end
    end
  end

  // Completion monitor for the timeout instance.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n && read2 && !waitrequest_2) begin
      if (exp2_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL resp2_unexpected: got readdata=%h fault=%b, expected no response", readdata_2, fault_2);
      end else begin
        r = exp2_q.pop_front();
        if (r.chk_rd) checkOutput("resp2_readdata", readdata_2, r.rd);
        checkOutput("resp2_fault", 32'(fault_2), 32'(r.flt));
      end
    end
  end

  // Write-pulse monitor: measures each fl_we_n low period and the address/data it carried.
  int          pw = 0;
  logic [26:0] pa;
  logic [15:0] pd;
  always @(negedge clk) begin
    pulse_t p;
    if (!fl_we_n) begin
      if (pw == 0) begin pa = fl_addr; pd = fl_dout; end
      pw++;
    end else if (pw > 0) begin
      if (pexp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL pulse_unexpected: got pulse addr=%h data=%h width=%0d, expected none", pa, pd, pw);
      end else begin
        p = pexp_q.pop_front();
        checkOutput("pulse_addr", 32'(pa), 32'(p.addr));
        checkOutput("pulse_data", 32'(pd), 32'(p.data));
        checkOutput("pulse_width", 32'(pw), 32'(p.width));
      end
      pw = 0;
    end
  end

  // Bus-contention and strobe-consistency watchdog.
  always @(negedge clk) begin
    if ((!fl_oe_n && fl_dout_en) || (!fl_we_n && (fl_ce_n || !fl_dout_en))) viol++;
  end

  initial begin
    int n;
    #12;
    checkOutput("rst_ce_n", 32'(fl_ce_n), 32'd1);
    checkOutput("rst_oe_n", 32'(fl_oe_n), 32'd1);
    checkOutput("rst_we_n", 32'(fl_we_n), 32'd1);
    checkOutput("rst_dout_en", 32'(fl_dout_en), 32'd0);
    checkOutput("rst_addr", 32'(fl_addr), 32'd0);
    checkOutput("rst_dout", 32'(fl_dout), 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_waitreq", 32'(waitrequest), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);

    pushResp(32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 27'h0000100, 32'h0, 4'h0, 11);

    pushPulse(27'h0000040, 16'h1234, 3);
    pushResp(32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 27'h0000041, 32'h12345678, 4'b1100, 8);

    pushPulse(27'h0000042, 16'h5678, 3);
    pushResp(32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 27'h0000041, 32'h12345678, 4'b0011, 8);

    pushResp(32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 27'h0000041, 32'h12345678, 4'b0000, 1);

    busy_len = 20;
    pushPulse(27'h0000040, 16'h1234, 3);
    pushPulse(27'h0000042, 16'h5678, 3);
    pushResp(32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 27'h0000040, 32'h12345678, 4'b1111, 55);
    busy_len = 0;
    repeat (3) @(posedge clk);

    pushResp(32'hA7A5A7A7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 27'h0000202, 32'hCAFEF00D, 4'b1111, 11);

    ry_hold = 1'b1;
    repeat (4) @(posedge clk);
    pushResp(32'hA6A5A6A7, 1'b1, 1'b0, 1'b0);
    fork
      applyStimulus(1'b0, 1'b1, 1'b0, 27'h0000300, 32'h0, 4'h0, -1);
      begin repeat (10) @(negedge clk); ry_hold = 1'b0; end
    join

    pushResp(32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 27'h0000000, 32'h0, 4'h0, 17);
    @(negedge clk);
    checkOutput("fault_single_cycle", 32'(fault_2), 32'd0);

    pushPulse(27'h0000040, 16'h1234, 1);
    @(posedge clk); #1;
    address = 27'h0000040; writedata = 32'h12345678; byteenable = 4'b1111; write = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (fl_we_n && n < 20);
    checkOutput("rst_pulse_seen", 32'(fl_we_n), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we_n", 32'(fl_we_n), 32'd1);
    checkOutput("rst_mid_dout_en", 32'(fl_dout_en), 32'd0);
    checkOutput("rst_mid_ce_n", 32'(fl_ce_n), 32'd1);
    write = 1'b0;
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("post_rst_waitreq", 32'(waitrequest), 32'd0);
      checkOutput("post_rst_we_n", 32'(fl_we_n), 32'd1);
      checkOutput("post_rst_ce_n", 32'(fl_ce_n), 32'd1);
    end

    checkOutput("scoreboard_drained", 32'(exp_q.size() + exp2_q.size() + pexp_q.size()), 32'd0);
    checkOutput("strobe_invariants", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
